// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and types for the branch target buffer: PC step, kernel bit,
// weak-taken counter encoding and the update decode used by the top.
package branch_predictor_btb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_STEP      = 4;
  localparam int KERNEL_BIT   = XLEN_DEFAULT - 1;
  localparam int CNT_W_MAX    = 3;

  // What the EX-stage update does to the array this cycle
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_ALLOC = 2'd2,
    UPD_FLUSH = 2'd3
  } upd_kind_e;

  // Counter value with only the MSB set: the weakest "taken" state
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_taken(input int cnt_w);
    return CNT_W_MAX'(1) << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down direction counter, one per BTB entry; the MSB is the
// taken prediction.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             taken
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken = cnt_q[CNT_W-1];

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// combinational IF lookup, EX-stage training, mispredict detection and perf counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int NO_KERNEL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            flush,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int TOP_BIT = XLEN - 1;
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(cnt_weak_taken(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [ENTRIES-1:0] cnt_taken;
  logic [31:0]        perf_lookups_q, perf_lookups_d;
  logic [31:0]        perf_mispred_q, perf_mispred_d;

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_block;
  logic               up_hit;
  upd_kind_e          upd_kind;
  logic [ENTRIES-1:0] train_sel;
  logic [ENTRIES-1:0] alloc_sel;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[XLEN-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
                  !((NO_KERNEL != 0) && if_pc[TOP_BIT]);

  assign pred_taken  = lk_hit && cnt_taken[lk_idx];
  assign pred_target = lk_hit ? target_q[lk_idx] : (if_pc + XLEN'(PC_STEP));

  // Held low during reset so the flush/redirect path stays quiet
  assign mispredict  = reset && upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(PC_STEP));

  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign up_block = (NO_KERNEL != 0) && upd_pc[TOP_BIT];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Flush takes priority over any training or allocation in the same cycle
  always_comb begin
    upd_kind = UPD_NONE;
    if (flush) begin
      upd_kind = UPD_FLUSH;
    end else if (upd_valid && !up_block) begin
      if (up_hit) begin
        upd_kind = UPD_TRAIN;
      end else if (upd_taken) begin
        upd_kind = UPD_ALLOC;
      end
    end
  end

  assign train_sel = (upd_kind == UPD_TRAIN) ? (ENTRIES'(1) << up_idx) : '0;
  assign alloc_sel = (upd_kind == UPD_ALLOC) ? (ENTRIES'(1) << up_idx) : '0;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    case (upd_kind)
      UPD_FLUSH: valid_d = '0;
      UPD_ALLOC: begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
      end
      UPD_TRAIN: begin
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    perf_lookups_d = perf_lookups_q + {31'd0, upd_valid};
    perf_mispred_d = perf_mispred_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      perf_lookups_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      valid_q        <= valid_d;
      perf_lookups_q <= perf_lookups_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  // Tag/target storage is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (train_sel[i] & upd_taken),
      .dec      (train_sel[i] & ~upd_taken),
      .load     (alloc_sel[i]),
      .load_val (CNT_WEAK_TAKEN),
      .taken    (cnt_taken[i])
    );
  end

  assign perf_lookups = perf_lookups_q;
  assign perf_mispred = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed plus randomized bench for branch_predictor_btb, checked against a
// behavioural BTB model (16 entries, 2-bit counters, kernel space excluded).
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispred;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_lookups = 0;
  logic [31:0] m_mispred = 0;

  branch_predictor_btb dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .flush           (flush),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .perf_lookups    (perf_lookups),
    .perf_mispred    (perf_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == (pc >> 6)) && (pc < 32'h8000_0000);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
    end
    m_lookups = 0;
    m_mispred = 0;
  endtask

  // Apply inputs just after a falling edge, check combinational outputs against
  // the model's pre-edge state, then advance the model across the rising edge.
  task automatic step(input logic [31:0] pc, input bit fl, input bit uv,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                      input bit upt, input logic [31:0] uptgt);
    bit          eh, emis, uh;
    int          li, ui;
    logic [31:0] etgt, eredir;
    if_pc = pc; flush = fl; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    #1;
    li     = m_idx(pc);
    eh     = m_hit(pc);
    etgt   = eh ? m_tgt[li] : pc + 32'd4;
    emis   = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    eredir = ut ? utgt : upc + 32'd4;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, eh && (m_cnt[li] >= 2)});
    chk("pred_target", pred_target, etgt);
    chk("mispredict", {31'd0, mispredict}, {31'd0, emis});
    chk("redirect_pc", redirect_pc, eredir);
    chk("perf_lookups", perf_lookups, m_lookups);
    chk("perf_mispred", perf_mispred, m_mispred);
    @(posedge clk);
    ui = m_idx(upc);
    uh = m_hit(upc);
    if (uv) m_lookups = m_lookups + 1;
    if (emis) m_mispred = m_mispred + 1;
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (uv && (upc < 32'h8000_0000)) begin
      if (uh) begin
        if (ut) begin
          m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
          m_tgt[ui] = utgt;
        end else begin
          m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[ui] = 1;
        m_tag[ui]   = upc >> 6;
        m_tgt[ui]   = utgt;
        m_cnt[ui]   = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    step(pc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input bit ut, input logic [31:0] utgt);
    step(pc, 0, 1, pc, ut, utgt, 1, 32'h100);
  endtask

  logic [31:0] rpc, rupc, rtgt;

  initial begin
    m_clear();
    // Reset state
    if_pc = 32'h40;
    #2;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h44);
    chk("rst_perf_lookups", perf_lookups, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Allocation, hit, and alias with a different tag
    step(32'h40, 0, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    look(32'h40);
    look(32'h80);

    // Counter saturation at 0x40
    for (int i = 0; i < 3; i++) train(32'h40, 0, 32'h0);
    train(32'h40, 1, 32'h100);
    for (int i = 0; i < 2; i++) train(32'h40, 1, 32'h100);
    for (int i = 0; i < 5; i++) train(32'h40, 1, 32'h100);
    look(32'h40);

    // Same-cycle update visible only afterwards; flush beats update
    step(32'h40, 0, 1, 32'h40, 1, 32'h120, 1, 32'h100);
    look(32'h40);
    step(32'h40, 1, 1, 32'h40, 1, 32'h140, 1, 32'h120);
    look(32'h40);
    step(32'h40, 1, 1, 32'h40, 1, 32'h140, 0, 32'h44);
    look(32'h40);

    // Mispredict / redirect vectors
    step(32'h0, 0, 1, 32'h40, 1, 32'h104, 1, 32'h100);
    step(32'h0, 0, 1, 32'h40, 0, 32'h104, 1, 32'h100);
    step(32'h0, 0, 1, 32'h7c, 1, 32'h200, 1, 32'h200);
    step(32'h0, 0, 1, 32'hfffffffc, 0, 32'h0, 0, 32'h0);

    // Kernel-space PCs never allocate
    step(32'h80000010, 0, 1, 32'h80000010, 1, 32'h300, 0, 32'h0);
    look(32'h80000010);

    // Perf counter wrap
    force dut.perf_lookups_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_lookups_q;
    m_lookups = 32'hFFFF_FFFF;
    step(32'h0, 0, 1, 32'h10, 0, 32'h0, 0, 32'h0);
    look(32'h0);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 400; n++) begin
      rupc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) rupc = rupc | 32'h8000_0000;
      rpc  = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2) |
             32'($urandom_range(0, 3));
      rtgt = 32'h1000 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      step(rpc, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), rupc,
           $urandom_range(0, 2) != 0, rtgt, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? rtgt : rtgt + 32'd4);
    end

    // Asynchronous reset mid-cycle with a valid entry
    step(32'h40, 0, 1, 32'h40, 1, 32'h200, 0, 32'h44);
    look(32'h40);
    if_pc = 32'h40; upd_valid = 1'b1; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("arst_pred_target", pred_target, 32'h44);
    chk("arst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("arst_perf_lookups", perf_lookups, 32'd0);
    chk("arst_perf_mispred", perf_mispred, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    reset = 1'b1;
    m_clear();
    look(32'h40);
    look(32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
